writeback_buffer: RTL and testbench

Writeback stage directly upstream of the register file write port. Accepts completed results from the execute/memory stage over a valid/ready handshake, selects the result source, and queues up to two pending writes. It presents the oldest pending write on `regWrite`/`writeRegister`/`writeData` until the phase strobe `changeEnable` commits it. It also flags read-after-write hazards to decode for writes that the register file's write-through forwarding cannot cover.

---
 rtl/writeback_buffer.sv | 110 +++++++++++
 tb/tb_writeback_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_buffer.sv
// writeback_buffer: small in-order result queue feeding the register file write port.
// Optional macro WB_HAZARD_STALL_EN: depth 2 with RAW stall; undefined gives depth 1, stall tied low.
module writeback_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_write,
  input  logic [2:0]  in_dest,
  input  logic [1:0]  in_sel,
  input  logic [15:0] in_alu,
  input  logic [15:0] in_load,
  input  logic [15:0] in_io,
  input  logic [15:0] in_imm,
  input  logic        changeEnable,
  output logic        regWrite,
  output logic [2:0]  writeRegister,
  output logic [15:0] writeData,
  input  logic [2:0]  Rs,
  input  logic [2:0]  Rd,
  output logic        stall,
  output logic [15:0] retired
);

  logic [2:0]  dest_q [DEPTH];
  logic [15:0] data_q [DEPTH];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] in_data;
  logic        tail;
  logic        push, pop;

  always_comb begin
    case (in_sel)
      2'b00:   in_data = in_alu;
      2'b01:   in_data = in_load;
      2'b10:   in_data = in_io;
      default: in_data = in_imm;
    endcase
  end

`ifdef WB_HAZARD_STALL_EN
  assign in_ready = (int'(count_q) < DEPTH);
  // Only two slots: the free slot is the head itself when empty, the other one otherwise.
  assign tail     = head_q ^ count_q[0];
`else
  assign in_ready = (count_q == 2'd0);
  assign tail     = 1'b0;
`endif

  assign regWrite      = (count_q != 2'd0);
  assign writeRegister = regWrite ? dest_q[head_q] : 3'd0;
  assign writeData     = regWrite ? data_q[head_q] : 16'd0;
  assign retired       = retired_q;

  assign push = in_valid & in_ready & in_write;
  assign pop  = regWrite & changeEnable;

  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    retired_d = retired_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    if (pop) begin
      retired_d = retired_q + 16'd1;
`ifdef WB_HAZARD_STALL_EN
      head_d    = ~head_q;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= 2'd0;
      head_q    <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      retired_q <= retired_d;
    end
  end

  // Payload storage needs no reset: the head outputs are masked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      dest_q[tail] <= in_dest;
      data_q[tail] <= in_data;
    end
  end

`ifdef WB_HAZARD_STALL_EN
  // The head is covered by register-file write-through; only the younger entry can hazard.
  logic [2:0] second_dest;
  assign second_dest = dest_q[~head_q];
  assign stall = (count_q == 2'd2) && ((second_dest == Rs) || (second_dest == Rd));
`else
  logic unused_read_addrs;
  assign unused_read_addrs = ^{Rs, Rd};
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: table of single-cycle vectors plus scripted
// multi-cycle sequences, with a commit scoreboard. Works in both WB_HAZARD_STALL_EN builds.
module tb_writeback_buffer;

`ifdef WB_HAZARD_STALL_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_write;
  logic [2:0]  in_dest;
  logic [1:0]  in_sel;
  logic [15:0] in_alu, in_load, in_io, in_imm;
  logic        changeEnable;
  logic        regWrite;
  logic [2:0]  writeRegister;
  logic [15:0] writeData;
  logic [2:0]  Rs, Rd;
  logic        stall;
  logic [15:0] retired;

  always #5 clock = ~clock;

  writeback_buffer #(.DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write),
    .in_dest(in_dest), .in_sel(in_sel),
    .in_alu(in_alu), .in_load(in_load), .in_io(in_io), .in_imm(in_imm),
    .changeEnable(changeEnable),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .Rs(Rs), .Rd(Rd), .stall(stall), .retired(retired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0]  dest;
    logic [15:0] data;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] ret_model = 16'd0;

  typedef struct {
    bit          v, w;
    logic [2:0]  d;
    logic [1:0]  s;
    logic [15:0] val;
    bit          ce;
    bit          e_rw;
    logic [2:0]  e_wr;
    logic [15:0] e_wd;
    int          e_cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mux_exp();
    case (in_sel)
      2'b00:   return in_alu;
      2'b01:   return in_load;
      2'b10:   return in_io;
      default: return in_imm;
    endcase
  endfunction

  function automatic bit stall_exp();
    if (CAP < 2 || sb.size() != 2) return 1'b0;
    return (sb[1].dest == Rs) || (sb[1].dest == Rd);
  endfunction

  task automatic drive(input bit v, input bit w, input logic [2:0] d, input logic [1:0] s,
                       input logic [15:0] val, input bit ce);
    in_valid = v; in_write = w; in_dest = d; in_sel = s; changeEnable = ce;
    in_alu  = val ^ 16'h1001;
    in_load = val ^ 16'h2002;
    in_io   = val ^ 16'h4004;
    in_imm  = val ^ 16'h8008;
    case (s)
      2'b00:   in_alu  = val;
      2'b01:   in_load = val;
      2'b10:   in_io   = val;
      default: in_imm  = val;
    endcase
  endtask

  // One clock: pre-edge checks, scoreboard update, edge, post-edge checks.
  task automatic step(input bit full_chk);
    ent_t        e;
    bit          com, acc;
    logic [2:0]  hd;
    logic [15:0] hdat;
    #1;
    com = !reset && changeEnable && (sb.size() != 0);
    acc = !reset && in_valid && (sb.size() < CAP);
    if (full_chk && !reset) begin
      check("pre_in_ready", in_ready, (sb.size() < CAP));
      check("pre_stall", stall, stall_exp());
    end
    if (com) begin
      e = sb.pop_front();
      check("commit_reg", writeRegister, e.dest);
      check("commit_data", writeData, e.data);
      ret_model = ret_model + 16'd1;
    end
    if (acc && in_write) sb.push_back({in_dest, mux_exp()});
    @(posedge clock);
    if (reset) begin
      sb.delete();
      ret_model = 16'd0;
    end
    #1;
    if (full_chk) begin
      hd   = (sb.size() != 0) ? sb[0].dest : 3'd0;
      hdat = (sb.size() != 0) ? sb[0].data : 16'd0;
      check("regWrite", regWrite, (sb.size() != 0));
      check("writeRegister", writeRegister, hd);
      check("writeData", writeData, hdat);
      check("in_ready", in_ready, (sb.size() < CAP));
      check("retired", retired, ret_model);
      check("stall", stall, stall_exp());
    end
  endtask

  task automatic idle(input bit ce, input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 3'd0, 2'd0, 16'd0, ce);
      step(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 1, 3'd7, 2'd0, 16'h1234, 0, 1, 3'd7, 16'h1234, 1};
    tbl[1] = '{0, 0, 3'd0, 2'd0, 16'h0000, 1, 0, 3'd0, 16'h0000, 0};
    tbl[2] = '{1, 1, 3'd2, 2'd1, 16'hAAAA, 0, 1, 3'd2, 16'hAAAA, 1};
    tbl[3] = '{0, 0, 3'd0, 2'd0, 16'h0000, 1, 0, 3'd0, 16'h0000, 0};
    tbl[4] = '{1, 1, 3'd0, 2'd2, 16'hBBBB, 0, 1, 3'd0, 16'hBBBB, 1};
    tbl[5] = '{0, 0, 3'd0, 2'd0, 16'h0000, 1, 0, 3'd0, 16'h0000, 0};
    tbl[6] = '{1, 1, 3'd5, 2'd3, 16'hCCCC, 0, 1, 3'd5, 16'hCCCC, 1};
    tbl[7] = '{0, 0, 3'd0, 2'd0, 16'h0000, 1, 0, 3'd0, 16'h0000, 0};
    tbl[8] = '{1, 0, 3'd4, 2'd0, 16'hDDDD, 0, 0, 3'd0, 16'h0000, 0};

    Rs = 3'd0; Rd = 3'd0;
    drive(0, 0, 3'd0, 2'd0, 16'd0, 0);
    reset = 1'b1;
    step(1); step(1);
    reset = 1'b0;
    #1;
    check("rst_regWrite", regWrite, 0);
    check("rst_writeRegister", writeRegister, 0);
    check("rst_writeData", writeData, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_retired", retired, 0);

    // Single write held until strobe
    drive(1, 1, 3'd3, 2'd1, 16'hBEEF, 0);
    step(1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 3'd0, 2'd0, 16'd0, 0);
      step(1);
      check("hold_regWrite", regWrite, 1);
      check("hold_writeRegister", writeRegister, 3);
      check("hold_writeData", writeData, 16'hBEEF);
    end
    drive(0, 0, 3'd0, 2'd0, 16'd0, 1);
    step(1);
    check("single_retired", retired, 1);
    check("single_empty", regWrite, 0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].d, tbl[i].s, tbl[i].val, tbl[i].ce);
      step(1);
      check("tbl_regWrite", regWrite, tbl[i].e_rw);
      check("tbl_writeRegister", writeRegister, tbl[i].e_wr);
      check("tbl_writeData", writeData, tbl[i].e_wd);
      check("tbl_in_ready", in_ready, (tbl[i].e_cnt < CAP));
    end

`ifdef WB_HAZARD_STALL_EN
    // Fill and back-pressure
    drive(1, 1, 3'd1, 2'd0, 16'h0011, 0); step(1);
    drive(1, 1, 3'd2, 2'd3, 16'h0022, 0); step(1);
    check("fill_in_ready", in_ready, 0);
    drive(1, 1, 3'd4, 2'd2, 16'h0044, 0); step(1);
    check("held_head", writeRegister, 1);
    changeEnable = 1'b1; step(1);
    check("after_pop_in_ready", in_ready, 1);
    changeEnable = 1'b0; step(1);
    check("third_accepted_ready", in_ready, 0);
    idle(1, 3);

    // Hazard on the younger entry only
    drive(1, 1, 3'd5, 2'd0, 16'h0505, 0); step(1);
    drive(1, 1, 3'd6, 2'd0, 16'h0606, 0); step(1);
    drive(0, 0, 3'd0, 2'd0, 16'd0, 0);
    Rs = 3'd6; Rd = 3'd0; #1; check("haz_rs6", stall, 1);
    Rs = 3'd5; #1; check("haz_rs5", stall, 0);
    Rs = 3'd0; Rd = 3'd6; #1; check("haz_rd6", stall, 1);
    changeEnable = 1'b1; step(1);
    changeEnable = 1'b0; #1;
    check("haz_after_commit", stall, 0);
    idle(1, 1);
    Rs = 3'd0; Rd = 3'd0;

    // Discard and simultaneous push/pop
    drive(1, 1, 3'd1, 2'd0, 16'h0101, 0); step(1);
    drive(1, 0, 3'd3, 2'd0, 16'h0303, 0); step(1);
    check("discard_reg", writeRegister, 1);
    check("discard_ready", in_ready, 1);
    drive(1, 1, 3'd7, 2'd2, 16'h7777, 1); step(1);
    check("simul_reg", writeRegister, 7);
    check("simul_data", writeData, 16'h7777);
    check("simul_ready", in_ready, 1);
    idle(1, 1);

    // Reset with a full queue, strobe held high
    drive(1, 1, 3'd2, 2'd0, 16'h2222, 0); step(1);
    drive(1, 1, 3'd3, 2'd0, 16'h3333, 0); step(1);
`else
    // Back-pressure at depth 1
    drive(1, 1, 3'd1, 2'd0, 16'h0011, 0); step(1);
    check("fill_in_ready", in_ready, 0);
    drive(1, 1, 3'd2, 2'd3, 16'h0022, 1); step(1);
    check("pop_then_ready", in_ready, 1);
    changeEnable = 1'b0; step(1);
    check("second_head", writeRegister, 2);
    idle(1, 2);
    drive(1, 0, 3'd3, 2'd0, 16'h0303, 0); step(1);
    check("discard_empty", regWrite, 0);

    drive(1, 1, 3'd2, 2'd0, 16'h2222, 0); step(1);
`endif
    drive(0, 0, 3'd0, 2'd0, 16'd0, 1);
    reset = 1'b1;
    step(1); step(1);
    reset = 1'b0;
    #1;
    check("mid_rst_regWrite", regWrite, 0);
    check("mid_rst_writeData", writeData, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_retired", retired, 0);
    idle(0, 1);

    // Commit counter
`ifdef WB_HAZARD_STALL_EN
    drive(1, 1, 3'd1, 2'd0, 16'h0001, 0); step(1);
    for (int i = 0; i < 65535; i++) begin
      drive(1, 1, i[2:0], 2'd0, i[15:0], 1);
      step(0);
    end
    #1;
    check("wrap_ffff", retired, 16'hFFFF);
    drive(1, 1, 3'd6, 2'd1, 16'h6666, 1); step(1);
    check("wrap_zero", retired, 16'h0000);
    idle(1, 2);
`else
    for (int i = 0; i < 500; i++) begin
      drive(1, 1, i[2:0], 2'd0, i[15:0], 0); step(0);
      drive(0, 0, 3'd0, 2'd0, 16'd0, 1); step(0);
    end
    #1;
    check("count_500", retired, 16'd500);
    idle(1, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
